// File: rtl/axi_lite_reg_checker.sv
// AXI4-Lite register checker: writes a seeded pattern to NUM_REGS registers, reads each back and tallies mismatches.
// Optional macro AXIL_CHK_TIMEOUT_EN adds a per-handshake timeout of TIMEOUT_CYC cycles.
module axi_lite_reg_checker #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          NUM_REGS    = 4,
    parameter logic [63:0] BASE_ADDR   = 64'd0,
    parameter logic [31:0] SEED        = 32'h0101FFFF,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [7:0]          fail_index,
    output logic [2:0]          dbg_state,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    if (NUM_REGS < 1 || NUM_REGS > 256 || TIMEOUT_CYC < 1 || (DATA_W != 32 && DATA_W != 64))
    begin : g_param_check
        $error("axi_lite_reg_checker: illegal parameter value");
    end

    localparam int          ROT_W   = $clog2(DATA_W);
    localparam int          ADDR_SH = $clog2(DATA_W / 8);
    localparam logic [7:0]  LAST_K  = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t              state, state_adv, state_nx;
    logic [7:0]          k;
    logic                aw_done, w_done, resp_err;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                restart, check_fail, log_err, timeout;
    logic [DATA_W-1:0]   seed_ext, exp_data;
    logic [2*DATA_W-1:0] seed_rot;
    logic [ADDR_W-1:0]   reg_addr;

    // Rotate-left via a doubled word: the upper half of {s,s}<<r is s rotated by r.
    assign seed_ext = DATA_W'(SEED);
    assign seed_rot = {seed_ext, seed_ext} << k[ROT_W-1:0];
    assign exp_data = seed_rot[2*DATA_W-1:DATA_W] ^ DATA_W'(k);
    assign reg_addr = ADDR_W'(BASE_ADDR) + (ADDR_W'(k) << ADDR_SH);

    assign m_axi_awaddr  = reg_addr;
    assign m_axi_araddr  = reg_addr;
    assign m_axi_wdata   = exp_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = (state == WR) && !aw_done;
    assign m_axi_wvalid  = (state == WR) && !w_done;
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_rready  = (state == RD_DATA);

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid  && m_axi_wready;
    assign b_hs  = m_axi_bvalid  && m_axi_bready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign r_hs  = m_axi_rvalid  && m_axi_rready;

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign pass      = (state == DONE) && (err_count == 16'd0);
    assign dbg_state = state;

    assign restart    = start && ((state == IDLE) || (state == DONE));
    // A failed write response and a failed read of the same register count once.
    assign check_fail = resp_err || (rresp_q != 2'b00) || (rdata_q != exp_data);
    assign log_err    = ((state == CHECK) && check_fail) || timeout;

    always_comb begin
        state_adv = state;
        case (state)
            IDLE:    if (start) state_adv = WR;
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_adv = WR_RESP;
            WR_RESP: if (b_hs) state_adv = RD_ADDR;
            RD_ADDR: if (ar_hs) state_adv = RD_DATA;
            RD_DATA: if (r_hs) state_adv = CHECK;
            CHECK:   state_adv = (k == LAST_K) ? DONE : WR;
            DONE:    if (start) state_adv = WR;
            default: state_adv = IDLE;
        endcase
    end

    assign state_nx = timeout ? DONE : state_adv;

`ifdef AXIL_CHK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;

    assign waiting = (state == WR) || (state == WR_RESP) || (state == RD_ADDR) || (state == RD_DATA);
    // Fires on the last allowed cycle only if the awaited handshake is not completing now.
    assign timeout = waiting && (state_adv == state) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge ACLK) begin
        if (!ARESETN || !waiting || (state_adv != state)) tmo_cnt <= '0;
        else                                            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            k          <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_err   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            err_count  <= 16'd0;
            fail_index <= 8'hFF;
        end else begin
            if (restart) begin
                k          <= '0;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
                resp_err   <= 1'b0;
                err_count  <= 16'd0;
                fail_index <= 8'hFF;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (b_hs)  resp_err <= (m_axi_bresp != 2'b00);
            if (r_hs) begin
                rdata_q <= m_axi_rdata;
                rresp_q <= m_axi_rresp;
            end
            if (state == CHECK) begin
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
                resp_err <= 1'b0;
                if (k != LAST_K) k <= k + 8'd1;
            end
            // err_count==0 marks the first failure of the run; it saturates and never wraps back to 0.
            if (log_err) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'd0)    fail_index <= k;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_checker.sv
// Bench for axi_lite_reg_checker: randomized-latency AXI4-Lite slave, scoreboard of expected writes, run-level model.
module tb_axi_lite_reg_checker;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam int          NUM_REGS = 4;
    localparam logic [31:0] SEED     = 32'h0101FFFF;
    localparam int          TMO      = 16;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, pass;
    logic [15:0]       err_count;
    logic [7:0]        fail_index;
    logic [2:0]        dbg_state;
    logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]        m_axi_awprot, m_axi_arprot;
    logic              m_axi_awvalid, m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid, m_axi_wready;
    logic [1:0]        m_axi_bresp, m_axi_rresp;
    logic              m_axi_bvalid, m_axi_bready;
    logic              m_axi_arvalid, m_axi_arready;
    logic              m_axi_rvalid, m_axi_rready;

    // clock / reset
    always #5 ACLK = ~ACLK;

    axi_lite_reg_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(64'd0),
        .SEED(SEED), .TIMEOUT_CYC(TMO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_index(fail_index), .dbg_state(dbg_state),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int          checks = 0;
    int          errors = 0;
    int          viol = 0;
    int          hang_len = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mem[0:255];

    bit cfg_rand = 1'b0;
    int cfg_aw = 0;
    int cfg_w = 0;
    int bresp_err_idx = -1;
    int stuck_idx = -1;
    int hang_idx = -1;

    logic        aw_got, w_got, ar_got, aw_pend, w_pend, ar_pend, b_fire, r_fire;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int          aw_delay, w_delay, ar_delay, b_delay, r_delay;
    logic [31:0] aw_addr_q, w_data_q, ar_addr_q;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: register k carries SEED rotated left by k, XORed with k, at byte address 4*k.
    function automatic logic [31:0] model_e(input int k);
        int          r = k % DATA_W;
        logic [31:0] s = SEED;
        logic [31:0] rot;
        rot = (r == 0) ? s : ((s << r) | (s >> (DATA_W - r)));
        return rot ^ 32'(k);
    endfunction

    function automatic logic [31:0] model_addr(input int k);
        return 32'(k * 4);
    endfunction

    function automatic int pick(input int fixed);
        if (cfg_rand)    return $urandom_range(0, 3);
        if (fixed >= 0)  return fixed;
        return 0;
    endfunction

    // slave driver
    task automatic slave_clear();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0;  m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0;  m_axi_rresp = 2'b00; m_axi_rdata = '0;
        aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
        aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
        b_fire = 1'b0; r_fire = 1'b0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
    endtask

    task automatic slave_step();
        int          idx;
        logic [63:0] exp_e;
        if ((m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid) viol++;
        if (m_axi_bready && !(aw_got && w_got)) viol++;
        if ((m_axi_awvalid && aw_got) || (m_axi_wvalid && w_got) || (m_axi_arvalid && ar_got)) viol++;
        if (aw_pend && !m_axi_awvalid) begin
            if (!done) viol++;
            aw_pend = 1'b0;
        end else if (aw_pend && m_axi_awaddr != aw_addr_q) viol++;
        if (w_pend && !m_axi_wvalid) begin
            if (!done) viol++;
            w_pend = 1'b0;
        end else if (w_pend && m_axi_wdata != w_data_q) viol++;
        if (ar_pend && !m_axi_arvalid) begin
            if (!done) viol++;
            hang_len = ar_wait;
            ar_pend = 1'b0;
        end else if (ar_pend && m_axi_araddr != ar_addr_q) viol++;

        if (b_fire) begin
            m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
            b_fire = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        end else if (aw_got && w_got && !m_axi_bvalid) begin
            if (b_wait >= b_delay) begin
                idx = int'(aw_addr_q[9:2]);
                mem[idx] = w_data_q;
                m_axi_bvalid = 1'b1;
                m_axi_bresp = (idx == bresp_err_idx) ? 2'b10 : 2'b00;
                b_wait = 0;
                check_eq("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check_eq("wr_addr", aw_addr_q, exp_e[63:32]);
                    check_eq("wr_data", w_data_q, exp_e[31:0]);
                end
            end else b_wait++;
        end
        b_fire = m_axi_bvalid && m_axi_bready;

        m_axi_awready = 1'b0;
        if (m_axi_awvalid && !aw_got) begin
            if (!aw_pend) begin
                aw_pend = 1'b1; aw_addr_q = m_axi_awaddr; aw_wait = 0; aw_delay = pick(cfg_aw);
                if (m_axi_awprot != 3'b000) viol++;
            end
            if (aw_wait >= aw_delay) begin
                m_axi_awready = 1'b1; aw_got = 1'b1; aw_pend = 1'b0;
            end else aw_wait++;
        end

        m_axi_wready = 1'b0;
        if (m_axi_wvalid && !w_got) begin
            if (!w_pend) begin
                w_pend = 1'b1; w_data_q = m_axi_wdata; w_wait = 0; w_delay = pick(cfg_w);
                if (m_axi_wstrb != 4'hF) viol++;
            end
            if (w_wait >= w_delay) begin
                m_axi_wready = 1'b1; w_got = 1'b1; w_pend = 1'b0; b_delay = pick(-1);
            end else w_wait++;
        end

        if (r_fire) begin
            m_axi_rvalid = 1'b0; m_axi_rdata = '0; r_fire = 1'b0; ar_got = 1'b0;
        end else if (ar_got && !m_axi_rvalid) begin
            if (r_wait >= r_delay) begin
                idx = int'(ar_addr_q[9:2]);
                m_axi_rdata = mem[idx];
                if (idx == stuck_idx) m_axi_rdata[0] = 1'b0;
                m_axi_rresp = 2'b00; m_axi_rvalid = 1'b1; r_wait = 0;
            end else r_wait++;
        end
        r_fire = m_axi_rvalid && m_axi_rready;

        m_axi_arready = 1'b0;
        if (m_axi_arvalid && !ar_got) begin
            if (!ar_pend) begin
                ar_pend = 1'b1; ar_addr_q = m_axi_araddr; ar_wait = 0; ar_delay = pick(-1);
                if (m_axi_arprot != 3'b000) viol++;
            end
            idx = int'(ar_addr_q[9:2]);
            if (idx != hang_idx && ar_wait >= ar_delay) begin
                m_axi_arready = 1'b1; ar_got = 1'b1; ar_pend = 1'b0; r_delay = pick(-1);
            end else ar_wait++;
        end
    endtask

    initial begin
        slave_clear();
        forever begin
            @(negedge ACLK);
            #1;
            if (!ARESETN) slave_clear();
            else          slave_step();
        end
    end

    // run driver
    task automatic pulse_start();
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge ACLK);
            cyc++;
        end
        check_eq({tag, "_done"}, done, 1);
    endtask

    task automatic run_and_check(input string tag, input bit stray);
        int          exp_err = 0;
        int          exp_fail = 255;
        logic [31:0] e;
        exp_q.delete();
        for (int k = 0; k < NUM_REGS; k++) begin
            e = model_e(k);
            exp_q.push_back({model_addr(k), e});
            if (k == bresp_err_idx || (k == stuck_idx && e[0] == 1'b1)) begin
                if (exp_err == 0) exp_fail = k;
                exp_err++;
            end
        end
        pulse_start();
        check_eq({tag, "_busy_start"}, busy, 1);
        check_eq({tag, "_done_start"}, done, 0);
        check_eq({tag, "_err_clr"}, err_count, 0);
        if (stray) begin
            repeat (3) @(negedge ACLK);
            start = 1'b1;
            @(negedge ACLK); start = 1'b0;
        end
        wait_done(tag);
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_err_count"}, err_count, exp_err);
        check_eq({tag, "_fail_index"}, fail_index, exp_fail);
        check_eq({tag, "_pass"}, pass, exp_err == 0);
        check_eq({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        check_eq({tag, "_status"}, {busy, done, pass}, 0);
        check_eq({tag, "_state"}, dbg_state, 0);
        check_eq({tag, "_err_count"}, err_count, 0);
        check_eq({tag, "_fail_index"}, fail_index, 8'hFF);
    endtask

    initial begin
        int cyc;
        int r;
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        check_idle_outputs("reset");
        ARESETN = 1'b1;
        @(negedge ACLK);

        cfg_rand = 1'b0; cfg_aw = 0; cfg_w = 0;
        run_and_check("zero_wait", 1'b0);
        cfg_aw = 3; cfg_w = 0;
        run_and_check("aw_late", 1'b0);
        cfg_aw = 0; cfg_w = 3;
        run_and_check("w_late", 1'b0);
        cfg_w = 0; bresp_err_idx = 2; stuck_idx = 3;
        run_and_check("faults", 1'b0);
        bresp_err_idx = -1; stuck_idx = -1;

        cfg_aw = 5; cfg_w = 5;
        exp_q.delete();
        pulse_start();
        cyc = 0;
        while (!m_axi_awvalid && cyc < 50) begin
            @(negedge ACLK);
            cyc++;
        end
        check_eq("rst_mid_awvalid", m_axi_awvalid, 1);
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        check_idle_outputs("rst_mid");
        cfg_aw = 0; cfg_w = 0;
        run_and_check("after_rst", 1'b0);

        cfg_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 5);
            bresp_err_idx = (r < NUM_REGS) ? r : -1;
            r = $urandom_range(0, 5);
            stuck_idx = (r < NUM_REGS) ? r : -1;
            run_and_check("random", i[0]);
        end
        cfg_rand = 1'b0; bresp_err_idx = -1; stuck_idx = -1;

`ifdef AXIL_CHK_TIMEOUT_EN
        hang_idx = 1;
        exp_q.delete();
        pulse_start();
        wait_done("tmo");
        check_eq("tmo_arvalid", m_axi_arvalid, 0);
        check_eq("tmo_pass", pass, 0);
        check_eq("tmo_err_count", err_count, 1);
        check_eq("tmo_fail_index", fail_index, 1);
        @(negedge ACLK);
        check_eq("tmo_arvalid_cycles", hang_len, TMO);
        hang_idx = -1;
        exp_q.delete();
`endif

        check_eq("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
